// File: rtl/pll_supervisor.sv
// pll_supervisor: sequences the main rPLL from the 27 MHz reference clock.
// It pulses the PLL reset and qualifies lock over a stability window.
// System reset is released only once lock has been stable for that window.
// A lock timeout triggers a bounded number of retries and then parks in FAULT.
// Loss of lock while running re-sequences the PLL.
// Optional feature: define PLL_SUP_LOSS_COUNT_EN to add o_lock_loss_count,
// a saturating 8-bit count of lock losses seen while running.
module pll_supervisor #(
  parameter int RESET_PULSE_CYCLES  = 27,
  parameter int LOCK_STABLE_CYCLES  = 2700,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_pll_lock,
  input  logic                             i_restart,
  output logic                             o_pll_reset,
  output logic                             o_sys_rst_n,
  output logic                             o_ready,
  output logic                             o_fault,
`ifdef PLL_SUP_LOSS_COUNT_EN
  output logic [7:0]                       o_lock_loss_count,
`endif
  output logic [$clog2(MAX_RETRIES+1)-1:0] o_retry_count
);

  localparam int PW = $clog2(RESET_PULSE_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [PW-1:0] PULSE_LAST   = PW'(RESET_PULSE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic          r_lockMeta;
  logic          r_lockSync;
  logic [PW-1:0] r_pulseCnt;
  logic [PW-1:0] w_pulseNext;
  logic [SW-1:0] r_stableCnt;
  logic [SW-1:0] w_stableNext;
  logic [TW-1:0] r_timeoutCnt;
  logic [TW-1:0] w_timeoutNext;
  logic [RW-1:0] r_retryCnt;
  logic [RW-1:0] w_retryNext;
  logic [RW-1:0] w_retryInc;
  logic          w_lossEvent;
  logic          r_pllReset;
  logic          r_sysRstN;
  logic          r_ready;
  logic          r_fault;

  assign w_retryInc = r_retryCnt + RW'(1);

  // Two-flop synchronizer: only r_lockSync is ever used by the sequencer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lockMeta <= 1'b0;
      r_lockSync <= 1'b0;
    end else begin
      r_lockMeta <= i_pll_lock;
      r_lockSync <= r_lockMeta;
    end
  end

  // Next-state and counter update; a timeout beats lock qualification, and restart beats everything.
  always_comb begin
    w_nextState   = r_state;
    w_pulseNext   = r_pulseCnt;
    w_stableNext  = r_stableCnt;
    w_timeoutNext = r_timeoutCnt;
    w_retryNext   = r_retryCnt;
    w_lossEvent   = 1'b0;

    case (r_state)
      RESET_PLL: begin
        if (r_pulseCnt == PULSE_LAST) begin
          w_nextState   = WAIT_LOCK;
          w_pulseNext   = '0;
          w_timeoutNext = '0;
          w_stableNext  = '0;
        end else begin
          w_pulseNext = r_pulseCnt + PW'(1);
        end
      end

      WAIT_LOCK, STABLE: begin
        if (r_timeoutCnt == TIMEOUT_LAST) begin
          w_retryNext   = w_retryInc;
          w_timeoutNext = '0;
          w_stableNext  = '0;
          w_pulseNext   = '0;
          w_nextState   = (w_retryInc == RETRY_MAX) ? FAULT : RESET_PLL;
        end else begin
          w_timeoutNext = r_timeoutCnt + TW'(1);
          if (!r_lockSync) begin
            w_nextState  = WAIT_LOCK;
            w_stableNext = '0;
          end else if (r_state == WAIT_LOCK) begin
            if (LOCK_STABLE_CYCLES == 1) begin
              w_nextState  = RUN;
              w_retryNext  = '0;
              w_stableNext = '0;
            end else begin
              w_nextState  = STABLE;
              w_stableNext = SW'(1);
            end
          end else if (r_stableCnt == STABLE_LAST) begin
            w_nextState  = RUN;
            w_retryNext  = '0;
            w_stableNext = '0;
          end else begin
            w_stableNext = r_stableCnt + SW'(1);
          end
        end
      end

      RUN: begin
        w_retryNext = '0;
        if (!r_lockSync) begin
          w_nextState = RESET_PLL;
          w_pulseNext = '0;
          w_lossEvent = 1'b1;
        end
      end

      FAULT: begin
        w_nextState = FAULT;
      end

      default: begin
        w_nextState   = RESET_PLL;
        w_pulseNext   = '0;
        w_stableNext  = '0;
        w_timeoutNext = '0;
        w_retryNext   = '0;
      end
    endcase

    if (i_restart) begin
      w_nextState   = RESET_PLL;
      w_pulseNext   = '0;
      w_stableNext  = '0;
      w_timeoutNext = '0;
      w_retryNext   = '0;
    end
  end

  // State, counters and Moore outputs; outputs are decoded from the next state so they change with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= RESET_PLL;
      r_pulseCnt   <= '0;
      r_stableCnt  <= '0;
      r_timeoutCnt <= '0;
      r_retryCnt   <= '0;
      r_pllReset   <= 1'b1;
      r_sysRstN    <= 1'b0;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_pulseCnt   <= w_pulseNext;
      r_stableCnt  <= w_stableNext;
      r_timeoutCnt <= w_timeoutNext;
      r_retryCnt   <= w_retryNext;
      r_pllReset   <= (w_nextState == RESET_PLL) || (w_nextState == FAULT);
      r_sysRstN    <= (w_nextState == RUN);
      r_ready      <= (w_nextState == RUN);
      r_fault      <= (w_nextState == FAULT);
    end
  end

  assign o_pll_reset   = r_pllReset;
  assign o_sys_rst_n   = r_sysRstN;
  assign o_ready       = r_ready;
  assign o_fault       = r_fault;
  assign o_retry_count = r_retryCnt;

`ifdef PLL_SUP_LOSS_COUNT_EN
  logic [7:0] r_lossCnt;

  // Saturating count of lock losses out of RUN; only the async reset clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lossCnt <= 8'd0;
    end else if (w_lossEvent && (r_lossCnt != 8'hFF)) begin
      r_lossCnt <= r_lossCnt + 8'd1;
    end
  end

  assign o_lock_loss_count = r_lossCnt;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor: directed test-plan scenarios followed by randomized lock/restart/reset
// stimulus, all checked against a timeline-based reference model of the supervisor.
`timescale 1ns/1ps
module tb_pll_supervisor;

  localparam int P = 4;
  localparam int S = 8;
  localparam int T = 32;
  localparam int R = 2;

  logic       clk;
  logic       rst_n;
  logic       pllLock;
  logic       restart;
  logic       pllReset;
  logic       sysRstN;
  logic       ready;
  logic       fault;
  logic [1:0] retryCount;
`ifdef PLL_SUP_LOSS_COUNT_EN
  logic [7:0] lossCount;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef enum int {M_PULSE, M_ACQ, M_RUN, M_FAULT} mode_t;
  mode_t mMode;
  int    mElapsed;
  int    mLockRun;
  int    mRetries;
  int    mLoss;
  logic  mD1;
  logic  mD2;

  pll_supervisor #(
    .RESET_PULSE_CYCLES (P),
    .LOCK_STABLE_CYCLES (S),
    .LOCK_TIMEOUT_CYCLES(T),
    .MAX_RETRIES        (R)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_pll_lock       (pllLock),
    .i_restart        (restart),
    .o_pll_reset      (pllReset),
    .o_sys_rst_n      (sysRstN),
    .o_ready          (ready),
    .o_fault          (fault),
`ifdef PLL_SUP_LOSS_COUNT_EN
    .o_lock_loss_count(lossCount),
`endif
    .o_retry_count    (retryCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelReset();
    mMode    = M_PULSE;
    mElapsed = 0;
    mLockRun = 0;
    mRetries = 0;
    mLoss    = 0;
    mD1      = 1'b0;
    mD2      = 1'b0;
  endtask

  task automatic enterPulse();
    mMode    = M_PULSE;
    mElapsed = 0;
    mLockRun = 0;
  endtask

  // One clock edge of the reference: phases measured by elapsed edges and lock run-length.
  task automatic modelEdge(input logic vNow, input logic rs);
    logic lockS;
    lockS = mD2;
    mD2   = mD1;
    mD1   = vNow;
    if (mMode == M_RUN && !lockS && mLoss < 255) mLoss++;
    if (rs) begin
      enterPulse();
      mRetries = 0;
    end else begin
      case (mMode)
        M_PULSE: begin
          mElapsed++;
          if (mElapsed == P) begin
            mMode    = M_ACQ;
            mElapsed = 0;
            mLockRun = 0;
          end
        end
        M_ACQ: begin
          mElapsed++;
          if (mElapsed == T) begin
            mRetries++;
            if (mRetries == R) mMode = M_FAULT;
            else enterPulse();
          end else if (lockS) begin
            mLockRun++;
            if (mLockRun == S) begin
              mMode    = M_RUN;
              mRetries = 0;
            end
          end else begin
            mLockRun = 0;
          end
        end
        M_RUN: if (!lockS) enterPulse();
        default: ;
      endcase
    end
  endtask

  task automatic checkOutput();
    logic expReset;
    logic expRun;
    logic expFault;
    expReset = (mMode == M_PULSE) || (mMode == M_FAULT);
    expRun   = (mMode == M_RUN);
    expFault = (mMode == M_FAULT);
    check("pllReset", 32'(pllReset), 32'(expReset));
    check("sysRstN", 32'(sysRstN), 32'(expRun));
    check("ready", 32'(ready), 32'(expRun));
    check("fault", 32'(fault), 32'(expFault));
    check("retryCount", 32'(retryCount), 32'(mRetries));
`ifdef PLL_SUP_LOSS_COUNT_EN
    check("lossCount", 32'(lossCount), 32'(mLoss));
`endif
  endtask

  // Drive one cycle of inputs, take the edge, advance the model and compare.
  task automatic applyStimulus(input logic lock, input logic rs);
    pllLock = lock;
    restart = rs;
    @(posedge clk);
    #1;
    cyc++;
    restart = 1'b0;
    modelEdge(lock, rs);
    checkOutput();
  endtask

  task automatic runTo(input int target, input logic lock);
    while (cyc < target) applyStimulus(lock, 1'b0);
  endtask

  // Assert reset between edges, confirm immediate reset values, then release to start cycle 0.
  task automatic doAsyncReset();
    rst_n   = 1'b0;
    restart = 1'b0;
    #1;
    check("rstPllReset", 32'(pllReset), 32'd1);
    check("rstSysRstN", 32'(sysRstN), 32'd0);
    check("rstReady", 32'(ready), 32'd0);
    check("rstFault", 32'(fault), 32'd0);
    check("rstRetry", 32'(retryCount), 32'd0);
`ifdef PLL_SUP_LOSS_COUNT_EN
    check("rstLoss", 32'(lossCount), 32'd0);
`endif
    modelReset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc   = 0;
    checkOutput();
  endtask

  initial begin
    int rate;
    logic lvl;
    rst_n   = 1'b0;
    pllLock = 1'b0;
    restart = 1'b0;
    modelReset();
    @(posedge clk);
    #1;

    // Nominal acquisition followed by lock loss in RUN and relock.
    doAsyncReset();
    runTo(3, 1'b0);
    check("nomPulseHigh", 32'(pllReset), 32'd1);
    runTo(4, 1'b0);
    check("nomPulseFall", 32'(pllReset), 32'd0);
    runTo(10, 1'b0);
    runTo(19, 1'b1);
    check("nomReadyEarly", 32'(ready), 32'd0);
    runTo(20, 1'b1);
    check("nomReady", 32'(ready), 32'd1);
    check("nomSysRstN", 32'(sysRstN), 32'd1);
    check("nomRetry", 32'(retryCount), 32'd0);
    runTo(50, 1'b1);
    runTo(52, 1'b0);
    check("lossSysStillHigh", 32'(sysRstN), 32'd1);
    runTo(53, 1'b0);
    check("lossSysRstN", 32'(sysRstN), 32'd0);
    check("lossPllReset", 32'(pllReset), 32'd1);
`ifdef PLL_SUP_LOSS_COUNT_EN
    check("lossCountOne", 32'(lossCount), 32'd1);
`endif
    runTo(64, 1'b1);
    check("relockEarly", 32'(ready), 32'd0);
    runTo(65, 1'b1);
    check("relockReady", 32'(ready), 32'd1);

    // Single-cycle lock glitch during qualification.
    doAsyncReset();
    runTo(10, 1'b0);
    runTo(14, 1'b1);
    runTo(15, 1'b0);
    runTo(24, 1'b1);
    check("glitchEarly", 32'(ready), 32'd0);
    runTo(25, 1'b1);
    check("glitchReady", 32'(ready), 32'd1);
    check("glitchRetry", 32'(retryCount), 32'd0);

    // Never locks: two timeouts into FAULT, then restart.
    doAsyncReset();
    runTo(35, 1'b0);
    check("toBefore", 32'(pllReset), 32'd0);
    runTo(36, 1'b0);
    check("to1Retry", 32'(retryCount), 32'd1);
    check("to1Pulse", 32'(pllReset), 32'd1);
    runTo(39, 1'b0);
    check("to1PulseEnd", 32'(pllReset), 32'd1);
    runTo(40, 1'b0);
    check("to1PulseFall", 32'(pllReset), 32'd0);
    runTo(71, 1'b0);
    check("to2FaultEarly", 32'(fault), 32'd0);
    runTo(72, 1'b0);
    check("to2Fault", 32'(fault), 32'd1);
    check("to2PllReset", 32'(pllReset), 32'd1);
    check("to2Retry", 32'(retryCount), 32'd2);
    runTo(80, 1'b1);
    check("faultHeld", 32'(fault), 32'd1);
    applyStimulus(1'b1, 1'b1);
    check("rsFaultClear", 32'(fault), 32'd0);
    check("rsRetryClear", 32'(retryCount), 32'd0);
    check("rsPulse", 32'(pllReset), 32'd1);
    runTo(84, 1'b1);
    check("rsPulseEnd", 32'(pllReset), 32'd1);
    runTo(85, 1'b1);
    check("rsPulseFall", 32'(pllReset), 32'd0);
    runTo(110, 1'b1);
    check("rsRelock", 32'(ready), 32'd1);

    // Reset asserted mid-STABLE, then a clean sequence.
    doAsyncReset();
    runTo(10, 1'b0);
    runTo(15, 1'b1);
    doAsyncReset();
    runTo(10, 1'b0);
    runTo(20, 1'b1);
    check("cleanReady", 32'(ready), 32'd1);

    // Randomized lock behaviour with occasional restart and async reset.
    rate = 10;
    lvl  = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) rate = $urandom_range(2, 40);
      if ($urandom_range(0, rate - 1) == 0) lvl = ~lvl;
      if ($urandom_range(0, 799) == 0) doAsyncReset();
      else applyStimulus(lvl, ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Sequences and supervises the main rPLL (27 MHz in, 81 MHz out). Runs on the 27 MHz board reference clock, because the PLL output cannot be trusted until it locks. The block drives the PLL RESET pin, qualifies LOCK over a stability window and releases the system reset only after lock is stable. On lock-acquisition timeout it retries a bounded number of times, then parks in a fault state; loss of lock during operation re-sequences the PLL.

## Interface
Parameters:
- RESET_PULSE_CYCLES, 27: cycles pll_reset is held high per attempt (1 µs); minimum 1.
- LOCK_STABLE_CYCLES, 2700: consecutive synchronized-lock cycles required before release (100 µs); minimum 1.
- LOCK_TIMEOUT_CYCLES, 270000: budget per attempt from pll_reset fall until RUN (10 ms); must exceed LOCK_STABLE_CYCLES+2.
- MAX_RETRIES, 3: failed attempts before FAULT; minimum 1.

Ports:
- CLK  in  1  27 MHz reference clock.
- RST_N  in  1  asynchronous, active-low reset.
- pll_lock  in  1  rPLL LOCK; asynchronous to CLK.
- restart  in  1  single-cycle request to re-sequence from any state.
- pll_reset  out  1  to rPLL RESET, active high.
- sys_rst_n  out  1  system reset release, active low, CLK domain. Consumers in the 81 MHz domain re-synchronize it.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_count  out  $clog2(MAX_RETRIES+1)  failed attempts in the current sequence.

## Operation
- pll_lock passes through a 2-flop synchronizer (lock_s). Only lock_s is used.
- All outputs are registered Moore outputs, decoded from the state and counters.
- Reset values: state=RESET_PLL, pll_reset=1, sys_rst_n=0, ready=0, fault=0, retry_count=0, all counters 0.
- States:
  - RESET_PLL: pll_reset=1. The pulse counter counts to RESET_PULSE_CYCLES, then the FSM moves to WAIT_LOCK and the timeout counter clears.
  - WAIT_LOCK: pll_reset=0. The timeout counter increments every cycle. lock_s=1 moves the FSM to STABLE and sets the stable counter to 1.
  - STABLE: the timeout counter keeps running.
    - lock_s=0 returns the FSM to WAIT_LOCK; the stable counter clears and the timeout counter does not.
    - When the stable counter reaches LOCK_STABLE_CYCLES, the FSM moves to RUN.
  - Timeout: in WAIT_LOCK or STABLE, when the timeout counter reaches LOCK_TIMEOUT_CYCLES, retry_count increments.
    - If the new value equals MAX_RETRIES, the FSM moves to FAULT.
    - Otherwise it moves to RESET_PLL.
    - Timeout takes priority over a same-cycle STABLE→RUN.
  - RUN: sys_rst_n=1, ready=1, pll_reset=0, retry_count=0. lock_s=0 moves the FSM to RESET_PLL (lock loss).
  - FAULT: pll_reset=1, sys_rst_n=0, fault=1. The FSM holds until restart or RST_N.
- restart in any state: next state is RESET_PLL, retry_count=0, counters cleared. restart overrides every other transition in the same cycle.
- sys_rst_n is 0 in every state except RUN. It falls on the edge the FSM leaves RUN.
- Counters are sized $clog2(param+1) and never wrap. retry_count cannot exceed MAX_RETRIES.

## Timing
- pll_reset falls exactly RESET_PULSE_CYCLES cycles after RST_N deassertion, or after entry to RESET_PLL.
- Lock-to-release latency: sys_rst_n and ready rise LOCK_STABLE_CYCLES+2 cycles after a pll_lock rising edge, provided the lock is held.
- Lock-loss response: sys_rst_n falls 3 cycles after pll_lock falls (2 synchronizer + 1 register), and pll_reset rises on the same edge.
- restart response: 1 cycle; outputs reflect RESET_PLL on the next edge.
- Asserting RST_N mid-operation forces reset values immediately, with no clock required.

## Configuration
- PLL_SUP_LOSS_COUNT_EN defined:
  - Adds output lock_loss_count (8 bits, saturating at 255).
  - Increments on each RUN→RESET_PLL transition caused by lock loss, including when restart coincides with the lock loss.
  - Clears only on RST_N.
- PLL_SUP_LOSS_COUNT_EN undefined: the port and its logic are absent.

## Test plan
Use parameters RESET_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Nominal: release RST_N at cycle 0, raise pll_lock at cycle 10 -> pll_reset=1 for cycles 0–3, sys_rst_n=ready=1 at cycle 20, retry_count=0.
- Lock glitch: pll_lock rises at 10, drops for 1 cycle at 14, stays high from 15 -> release is delayed to cycle 25 (8+2 after the re-rise); no retry is counted.
- Never locks: pll_lock=0 throughout -> timeout at 36 with retry_count=1 and a pll_reset pulse for cycles 36–39; second timeout at 72 -> FAULT, fault=1, pll_reset held at 1, retry_count=2.
- Lock loss in RUN: drop pll_lock at cycle 50 -> sys_rst_n=0 and pll_reset=1 at cycle 53; relock re-releases. With PLL_SUP_LOSS_COUNT_EN defined, lock_loss_count=1.
- Restart from FAULT: pulse restart -> next cycle fault=0, retry_count=0, pll_reset pulse of 4 cycles, normal sequence follows.
- RST_N asserted mid-STABLE -> all outputs at reset values immediately; a clean sequence follows release.
